// File: rtl/ex_issue_pkg.sv
// Shared types for the EX issue stage: ALU opcodes, forwarding select, held-entry layout.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package ex_issue_pkg;

    // Datapath width; the held entry is laid out for 32-bit operands only.
    localparam int XLEN_W = 32;
    localparam int REG_W  = 5;

    // ALU opcode encoding, shared with decode and the ALU.
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SLL  = 3'b001,
        ALU_SLT  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SRL  = 3'b101,
        ALU_OR   = 3'b110,
        ALU_AND  = 3'b111
    } alu_op_e;

    // Operand source chosen by the forwarding network, in priority order.
    typedef enum logic [1:0] {
        FWD_ZERO = 2'd0,
        FWD_EXM  = 2'd1,
        FWD_MWB  = 2'd2,
        FWD_REG  = 2'd3
    } fwd_sel_e;

    // Everything latched when decode hands over an instruction.
    typedef struct packed {
        logic [XLEN_W-1:0] pc;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [XLEN_W-1:0] rs1_data;
        logic [XLEN_W-1:0] rs2_data;
        logic [XLEN_W-1:0] imm;
        logic              use_imm;
        logic              use_pc;
        alu_op_e           alu_op;
        logic              alu_sub;
        logic              wen;
        logic              is_load;
    } ex_entry_t;

    // x0 is hardwired zero; a load in EX/MEM has no data yet, so it never forwards
    // (the hazard stall covers that case); EX/MEM is younger than MEM/WB and wins.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] exm_rd,
        input logic             exm_wen,
        input logic             exm_is_load,
        input logic [REG_W-1:0] mwb_rd,
        input logic             mwb_wen
    );
        if (rs == '0) begin
            return FWD_ZERO;
        end
        if (exm_wen && !exm_is_load && (exm_rd == rs)) begin
            return FWD_EXM;
        end
        if (mwb_wen && (mwb_rd == rs)) begin
            return FWD_MWB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/ex_issue_fwd_mux.sv
// Per-source operand forwarding mux (zero / EX-MEM / MEM-WB / latched register data).
// Latency: purely combinational, re-evaluated every cycle on the held source index.
// Backpressure: none; the caller decides when the result is consumed.
module fwd_mux
    import ex_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  rs_data,
    input  logic [REG_W-1:0] exm_rd,
    input  logic             exm_wen,
    input  logic             exm_is_load,
    input  logic [XLEN-1:0]  exm_data,
    input  logic [REG_W-1:0] mwb_rd,
    input  logic             mwb_wen,
    input  logic [XLEN-1:0]  mwb_data,
    output logic [XLEN-1:0]  data
);

    fwd_sel_e sel;

    // Pick the freshest producer for this source register.
    always_comb begin
        sel  = fwd_select(rs, exm_rd, exm_wen, exm_is_load, mwb_rd, mwb_wen);
        data = rs_data;
        case (sel)
            FWD_ZERO: data = '0;
            FWD_EXM:  data = exm_data;
            FWD_MWB:  data = mwb_data;
            FWD_REG:  data = rs_data;
            default:  data = rs_data;
        endcase
    end

endmodule

// File: rtl/ex_issue.sv
// Single-entry EX issue register with operand forwarding and load-use stall.
// Latency: one cycle from accept to presentation on out_*; back-to-back issue+accept has no bubble.
// Backpressure: in_ready drops while held and not issuing (out_ready low or load-use hazard) or on flush.
module ex_issue
    import ex_issue_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic [REG_W-1:0] in_rd,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_use_imm,
    input  logic             in_use_pc,
    input  logic [2:0]       in_alu_op,
    input  logic             in_alu_sub,
    input  logic             in_wen,
    input  logic             in_is_load,

    input  logic             flush,

    input  logic [REG_W-1:0] exm_rd,
    input  logic             exm_wen,
    input  logic             exm_is_load,
    input  logic [XLEN-1:0]  exm_data,

    input  logic [REG_W-1:0] mwb_rd,
    input  logic             mwb_wen,
    input  logic [XLEN-1:0]  mwb_data,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_op1,
    output logic [XLEN-1:0]  alu_op2,
    output logic [2:0]       alu_opcode,
    output logic             alu_sub,
    output logic [XLEN-1:0]  out_pc,
    output logic [REG_W-1:0] out_rd,
    output logic             out_wen,
    output logic             out_is_load,
    output logic [XLEN-1:0]  out_store_data
);

    logic            valid_q;
    ex_entry_t       entry_q;
    ex_entry_t       entry_d;
    logic [XLEN-1:0] last_op1_q;
    logic [XLEN-1:0] last_op2_q;
    logic [XLEN-1:0] last_sd_q;

    logic            hazard;
    logic            accept;
    logic            issue;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic [XLEN-1:0] op1_live;
    logic [XLEN-1:0] op2_live;

    // Pack the decode handoff into one entry so the capture is a single assignment.
    always_comb begin
        entry_d          = '0;
        entry_d.pc       = in_pc;
        entry_d.rs1      = in_rs1;
        entry_d.rs2      = in_rs2;
        entry_d.rd       = in_rd;
        entry_d.rs1_data = in_rs1_data;
        entry_d.rs2_data = in_rs2_data;
        entry_d.imm      = in_imm;
        entry_d.use_imm  = in_use_imm;
        entry_d.use_pc   = in_use_pc;
        entry_d.alu_op   = alu_op_e'(in_alu_op);
        entry_d.alu_sub  = in_alu_sub;
        entry_d.wen      = in_wen;
        entry_d.is_load  = in_is_load;
    end

    // A load still in EX/MEM cannot forward; stall if either held source needs its result.
    // Both sources are compared regardless of use_imm/use_pc, which is conservative but safe.
    assign hazard = valid_q && exm_wen && exm_is_load && (exm_rd != '0) &&
                    ((exm_rd == entry_q.rs1) || (exm_rd == entry_q.rs2));

    assign in_ready  = (!valid_q || (out_ready && !hazard)) && !flush;
    assign out_valid = valid_q && !hazard && !flush;
    assign accept    = in_valid && in_ready;
    assign issue     = out_valid && out_ready;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs          (entry_q.rs1),
        .rs_data     (entry_q.rs1_data),
        .exm_rd      (exm_rd),
        .exm_wen     (exm_wen),
        .exm_is_load (exm_is_load),
        .exm_data    (exm_data),
        .mwb_rd      (mwb_rd),
        .mwb_wen     (mwb_wen),
        .mwb_data    (mwb_data),
        .data        (fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs          (entry_q.rs2),
        .rs_data     (entry_q.rs2_data),
        .exm_rd      (exm_rd),
        .exm_wen     (exm_wen),
        .exm_is_load (exm_is_load),
        .exm_data    (exm_data),
        .mwb_rd      (mwb_rd),
        .mwb_wen     (mwb_wen),
        .mwb_data    (mwb_data),
        .data        (fwd_rs2)
    );

    assign op1_live = entry_q.use_pc  ? entry_q.pc  : fwd_rs1;
    assign op2_live = entry_q.use_imm ? entry_q.imm : fwd_rs2;

    // With nothing held the forwarding inputs keep moving, so operands are frozen
    // at whatever was last presented instead of tracking unrelated producers.
    assign alu_op1        = valid_q ? op1_live : last_op1_q;
    assign alu_op2        = valid_q ? op2_live : last_op2_q;
    assign out_store_data = valid_q ? fwd_rs2  : last_sd_q;

    // Control fields only change on accept, so they hold naturally when empty.
    assign alu_opcode  = entry_q.alu_op;
    assign alu_sub     = entry_q.alu_sub;
    assign out_pc      = entry_q.pc;
    assign out_rd      = entry_q.rd;
    assign out_wen     = entry_q.wen;
    assign out_is_load = entry_q.is_load;

    // Occupancy: flush kills and blocks refill; accept wins over a same-cycle issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
        end else if (issue) begin
            valid_q <= 1'b0;
        end
    end

    // Capture the decode handoff on accept only; accept already excludes flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (accept) begin
            entry_q <= entry_d;
        end
    end

    // Track the operands currently presented so they can be held once the entry empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_op1_q <= '0;
            last_op2_q <= '0;
            last_sd_q  <= '0;
        end else if (valid_q) begin
            last_op1_q <= op1_live;
            last_op2_q <= op2_live;
            last_sd_q  <= fwd_rs2;
        end
    end

endmodule

// File: tb/tb_ex_issue.sv
// Bench for ex_issue: directed vector table, reset-mid-stall sequence, randomized run vs reference model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 4 units after it.
// Backpressure: out_ready is driven from the vectors or randomly.
module tb_ex_issue;
    import ex_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_use_imm, in_use_pc;
    logic [2:0]  in_alu_op;
    logic        in_alu_sub, in_wen, in_is_load;
    logic        flush;
    logic [4:0]  exm_rd;
    logic        exm_wen, exm_is_load;
    logic [31:0] exm_data;
    logic [4:0]  mwb_rd;
    logic        mwb_wen;
    logic [31:0] mwb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_op1, alu_op2;
    logic [2:0]  alu_opcode;
    logic        alu_sub;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_wen, out_is_load;
    logic [31:0] out_store_data;

    always #5 clk = ~clk;

    ex_issue #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
        .in_alu_op(in_alu_op), .in_alu_sub(in_alu_sub),
        .in_wen(in_wen), .in_is_load(in_is_load),
        .flush(flush),
        .exm_rd(exm_rd), .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_data(exm_data),
        .mwb_rd(mwb_rd), .mwb_wen(mwb_wen), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_opcode(alu_opcode), .alu_sub(alu_sub),
        .out_pc(out_pc), .out_rd(out_rd), .out_wen(out_wen), .out_is_load(out_is_load),
        .out_store_data(out_store_data)
    );

    typedef struct {
        logic        in_valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        use_imm, use_pc;
        logic [2:0]  op;
        logic        sub, wen, is_load, flush;
        logic [4:0]  exm_rd;
        logic        exm_wen, exm_is_load;
        logic [31:0] exm_data;
        logic [4:0]  mwb_rd;
        logic        mwb_wen;
        logic [31:0] mwb_data;
        logic        out_ready;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        ov, ir, chk_ops;
        logic [31:0] op1, op2;
        logic [2:0]  opc;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic stim_t idle(input logic ordy);
        stim_t t;
        t = '{default: '0};
        t.out_ready = ordy;
        return t;
    endfunction

    function automatic stim_t instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                    input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                                    input logic use_imm, input logic [2:0] op, input logic ordy);
        stim_t t;
        t = idle(ordy);
        t.in_valid = 1'b1;
        t.pc       = 32'h0000_0100;
        t.rs1      = rs1;
        t.rs2      = rs2;
        t.rd       = rd;
        t.d1       = d1;
        t.d2       = d2;
        t.imm      = imm;
        t.use_imm  = use_imm;
        t.op       = op;
        t.wen      = 1'b1;
        return t;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic ov, input logic ir, input logic chk,
                                 input logic [31:0] op1, input logic [31:0] op2, input logic [2:0] opc);
        vec_t v;
        v.s = s; v.ov = ov; v.ir = ir; v.chk_ops = chk;
        v.op1 = op1; v.op2 = op2; v.opc = opc;
        return v;
    endfunction

    task automatic apply(input stim_t t);
        in_valid    = t.in_valid;    in_pc       = t.pc;
        in_rs1      = t.rs1;         in_rs2      = t.rs2;       in_rd = t.rd;
        in_rs1_data = t.d1;          in_rs2_data = t.d2;        in_imm = t.imm;
        in_use_imm  = t.use_imm;     in_use_pc   = t.use_pc;
        in_alu_op   = t.op;          in_alu_sub  = t.sub;
        in_wen      = t.wen;         in_is_load  = t.is_load;   flush = t.flush;
        exm_rd      = t.exm_rd;      exm_wen     = t.exm_wen;
        exm_is_load = t.exm_is_load; exm_data    = t.exm_data;
        mwb_rd      = t.mwb_rd;      mwb_wen     = t.mwb_wen;   mwb_data = t.mwb_data;
        out_ready   = t.out_ready;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference forwarding rule: x0 reads zero, then non-load EX/MEM, then MEM/WB, then regfile.
    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] regd, input stim_t c);
        if (rs == 5'd0) return 32'd0;
        if (c.exm_wen && !c.exm_is_load && c.exm_rd == rs) return c.exm_data;
        if (c.mwb_wen && c.mwb_rd == rs) return c.mwb_data;
        return regd;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[$];
        stim_t s;
        stim_t m_h;
        logic  m_valid;
        logic [31:0] m_op1, m_op2, m_sd;
        logic [31:0] e_op1, e_op2, e_sd, f1, f2;
        logic  hz, e_ov, e_ir;

        // Directed sequence; each row is one cycle and state carries over row to row.
        s = instr(0, 0, 1, 0, 0, 5, 1, ALU_ADD, 1);           tbl.push_back(mkv(s, 0, 1, 0, 0, 0, 0));
        s = idle(1);                                          tbl.push_back(mkv(s, 1, 1, 1, 0, 5, ALU_ADD));
        s = instr(3, 5, 6, 32'hAAAA, 7, 0, 0, ALU_ADD, 1);    tbl.push_back(mkv(s, 0, 1, 0, 0, 0, 0));
        s = idle(0); s.exm_wen = 1; s.exm_rd = 3; s.exm_data = 32'h10;
        s.mwb_wen = 1; s.mwb_rd = 3; s.mwb_data = 32'h20;     tbl.push_back(mkv(s, 1, 0, 1, 32'h10, 7, ALU_ADD));
        s.exm_wen = 0; s.out_ready = 1;                       tbl.push_back(mkv(s, 1, 1, 1, 32'h20, 7, ALU_ADD));
        s = instr(4, 0, 7, 32'h1111, 0, 1, 1, ALU_ADD, 1);    tbl.push_back(mkv(s, 0, 1, 0, 0, 0, 0));
        s = idle(1); s.exm_wen = 1; s.exm_is_load = 1; s.exm_rd = 4; s.exm_data = 32'hDEAD;
                                                              tbl.push_back(mkv(s, 0, 0, 0, 0, 0, 0));
        s = idle(1); s.mwb_wen = 1; s.mwb_rd = 4; s.mwb_data = 32'h44;
                                                              tbl.push_back(mkv(s, 1, 1, 1, 32'h44, 1, ALU_ADD));
        s = instr(0, 0, 8, 32'h55, 32'h66, 0, 0, ALU_XOR, 1); tbl.push_back(mkv(s, 0, 1, 0, 0, 0, 0));
        s = idle(1); s.exm_wen = 1; s.exm_rd = 0; s.exm_data = 32'hFFFF;
        s.mwb_wen = 1; s.mwb_rd = 0; s.mwb_data = 32'hFFFF;   tbl.push_back(mkv(s, 1, 1, 1, 0, 0, ALU_XOR));
        s = instr(1, 2, 9, 1, 2, 0, 0, ALU_SLL, 1); s.flush = 1;
                                                              tbl.push_back(mkv(s, 0, 0, 0, 0, 0, 0));
        s = idle(1);                                          tbl.push_back(mkv(s, 0, 1, 0, 0, 0, 0));
        s = instr(1, 0, 10, 32'h100, 0, 2, 1, ALU_OR, 1);     tbl.push_back(mkv(s, 0, 1, 0, 0, 0, 0));
        s = idle(1); s.flush = 1;                             tbl.push_back(mkv(s, 0, 0, 1, 32'h100, 2, ALU_OR));
        s = idle(1);                                          tbl.push_back(mkv(s, 0, 1, 1, 32'h100, 2, ALU_OR));
        s = instr(7, 8, 11, 32'h70, 32'h80, 0, 0, ALU_AND, 1); tbl.push_back(mkv(s, 0, 1, 0, 0, 0, 0));
        s = instr(9, 0, 12, 32'h90, 0, 3, 1, ALU_SLT, 0);
        for (int k = 0; k < 3; k++)                           tbl.push_back(mkv(s, 1, 0, 1, 32'h70, 32'h80, ALU_AND));
        s.out_ready = 1;                                      tbl.push_back(mkv(s, 1, 1, 1, 32'h70, 32'h80, ALU_AND));
        s = idle(0);                                          tbl.push_back(mkv(s, 1, 0, 1, 32'h90, 3, ALU_SLT));
        s = idle(1);                                          tbl.push_back(mkv(s, 1, 1, 1, 32'h90, 3, ALU_SLT));
        s = idle(1);                                          tbl.push_back(mkv(s, 0, 1, 1, 32'h90, 3, ALU_SLT));
        s = idle(1); s.exm_wen = 1; s.exm_rd = 9; s.exm_data = 32'hBEEF;
                                                              tbl.push_back(mkv(s, 0, 1, 1, 32'h90, 3, ALU_SLT));

        // Reset state.
        rst_n = 1'b0;
        apply(idle(1));
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_alu_op2", alu_op2, 32'd0);
        chk("rst_store_data", out_store_data, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_ctrl", {26'd0, alu_opcode, alu_sub, out_wen, out_is_load}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            apply(tbl[i].s);
            #3;
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            if (tbl[i].chk_ops) begin
                chk($sformatf("tbl%0d_alu_op1", i), alu_op1, tbl[i].op1);
                chk($sformatf("tbl%0d_alu_op2", i), alu_op2, tbl[i].op2);
                chk($sformatf("tbl%0d_opcode", i), 32'(alu_opcode), 32'(tbl[i].opc));
            end
        end

        // Reset while stalled discards the held instruction.
        @(posedge clk); #1;
        apply(instr(5, 6, 13, 32'h5, 32'h6, 0, 0, ALU_SRL, 1));
        @(posedge clk); #1;
        apply(idle(0));
        #2;
        chk("stall_held_valid", 32'(out_valid), 32'd1);
        chk("stall_held_rd", 32'(out_rd), 32'd13);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_pc", out_pc, 32'd0);
        chk("midrst_out_rd", 32'(out_rd), 32'd0);
        chk("midrst_alu_op1", alu_op1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(idle(1));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #4;
            chk($sformatf("postrst%0d_out_valid", k), 32'(out_valid), 32'd0);
            chk($sformatf("postrst%0d_in_ready", k), 32'(in_ready), 32'd1);
        end

        // Randomized run against the reference model, starting from the reset state.
        m_valid = 1'b0;
        m_h     = idle(0);
        m_op1   = 32'd0; m_op2 = 32'd0; m_sd = 32'd0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            s.in_valid    = ($urandom_range(0, 9) < 7);
            s.pc          = $urandom;
            s.rs1         = 5'($urandom_range(0, 3));
            s.rs2         = 5'($urandom_range(0, 3));
            s.rd          = 5'($urandom_range(0, 31));
            s.d1          = $urandom;
            s.d2          = $urandom;
            s.imm         = $urandom;
            s.use_imm     = 1'($urandom_range(0, 1));
            s.use_pc      = ($urandom_range(0, 3) == 0);
            s.op          = 3'($urandom_range(0, 7));
            s.sub         = 1'($urandom_range(0, 1));
            s.wen         = 1'($urandom_range(0, 1));
            s.is_load     = ($urandom_range(0, 3) == 0);
            s.flush       = ($urandom_range(0, 9) == 0);
            s.exm_rd      = 5'($urandom_range(0, 3));
            s.exm_wen     = 1'($urandom_range(0, 1));
            s.exm_is_load = ($urandom_range(0, 2) == 0);
            s.exm_data    = $urandom;
            s.mwb_rd      = 5'($urandom_range(0, 3));
            s.mwb_wen     = 1'($urandom_range(0, 1));
            s.mwb_data    = $urandom;
            s.out_ready   = ($urandom_range(0, 9) < 7);
            apply(s);
            #3;

            f1 = ref_fwd(m_h.rs1, m_h.d1, s);
            f2 = ref_fwd(m_h.rs2, m_h.d2, s);
            hz = m_valid && s.exm_wen && s.exm_is_load && (s.exm_rd != 0) &&
                 ((s.exm_rd == m_h.rs1) || (s.exm_rd == m_h.rs2));
            e_ov = m_valid && !hz && !s.flush;
            e_ir = (!m_valid || (s.out_ready && !hz)) && !s.flush;
            if (m_valid) begin
                m_op1 = m_h.use_pc  ? m_h.pc  : f1;
                m_op2 = m_h.use_imm ? m_h.imm : f2;
                m_sd  = f2;
            end
            e_op1 = m_op1; e_op2 = m_op2; e_sd = m_sd;

            chk("rnd_out_valid", 32'(out_valid), 32'(e_ov));
            chk("rnd_in_ready", 32'(in_ready), 32'(e_ir));
            chk("rnd_alu_op1", alu_op1, e_op1);
            chk("rnd_alu_op2", alu_op2, e_op2);
            chk("rnd_store_data", out_store_data, e_sd);
            chk("rnd_out_pc", out_pc, m_h.pc);
            chk("rnd_ctrl", {19'd0, out_rd, alu_opcode, alu_sub, out_wen, out_is_load},
                {19'd0, m_h.rd, m_h.op, m_h.sub, m_h.wen, m_h.is_load});

            if (s.flush) begin
                m_valid = 1'b0;
            end else if (s.in_valid && e_ir) begin
                m_valid = 1'b1;
                m_h     = s;
            end else if (e_ov && s.out_ready) begin
                m_valid = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
